smooth_filter_ctrl: RTL and testbench
=====================================

Name: smooth_filter_ctrl

Overview:
- Sequencer for the 8-bit mode-selectable smoothing filter. The filter has free-running taps and no enable; its modes are 0 = bypass, 1 = 3-tap, 2 = 5-tap, 3 = 7-tap.
- Owns the filter's mode input, applies mode-change requests at safe points, tracks window fill and pipeline latency, and flags which filter outputs are valid.
- Sits between the stream source / config master and the filter instance. Data din goes straight to the filter; only valid and control pass through this block.

Parameters:
- SAFE_SWITCH, 1: 1 = defer a mode change until a stream gap (din_valid low); 0 = apply immediately.
- RESET_MODE, 2'd0: filter mode driven out of reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- din_valid  in  1  source sample valid this cycle; the filter shifts every clk regardless
- cfg_req  in  1  mode-change request, level, held until cfg_ack
- cfg_mode  in  2  requested mode, stable while cfg_req high
- cfg_ack  out  1  one-cycle pulse: request applied
- flt_mode  out  2  registered mode to the filter
- flt_dout  in  8  filter output
- dout_valid  out  1  flt_dout holds a full-window result this cycle
- dout  out  8  dout_valid ? flt_dout : 8'd0 (combinational)
- busy  out  1  high when state != RUN

Behaviour:
- Per-mode constants:
  - Window W = 1/3/5/7 for modes 0/1/2/3.
  - Latency L = 1 for mode 0, 3 for modes 1-3 (edges from sample acceptance to flt_dout).
- Fill counter cnt (3 bit, saturates at 7):
  - din_valid=1: cnt <= min(cnt+1, 7).
  - din_valid=0: cnt <= 0.
  - Mode apply: cnt <= 0.
- Window flag: win_ok = din_valid && (cnt+1 >= W).
- Valid pipe vpipe[2:0]:
  - vpipe[0] <= win_ok; the pipe shifts every clk.
  - dout_valid = vpipe[L-1] for the current flt_mode.
  - Mode apply clears vpipe. A stream gap does not clear it, so in-flight results drain valid.
- First dout_valid cycle = first sample cycle + (W-1) + L, given a continuous stream.
- FSM states FILL, RUN, PEND. Reset enters FILL.
  - FILL: cfg_req (and cfg_ack low) -> apply, stay FILL. dout_valid=1 -> RUN.
  - RUN: din_valid=0 -> FILL.
  - RUN with cfg_req: if SAFE_SWITCH=1 and din_valid=1 -> PEND, else apply -> FILL.
  - PEND: wait for din_valid=0, then apply -> FILL.
  - PEND: cfg_req deasserted before ack -> cancel back to RUN, no apply.
  - PEND: dout_valid keeps running normally.
- Apply decided in cycle t. At the edge ending t:
  - flt_mode <= cfg_mode; cnt <= 0; vpipe <= 0; cfg_ack <= 1.
  - cfg_ack is high only in cycle t+1. cfg_req is ignored in any cycle where cfg_ack is high (no double apply).
  - A sample with din_valid in cycle t does not count toward the new window.
- cfg_mode equal to the current flt_mode: still acked, but no flush. cnt, vpipe and state are untouched.
- Simultaneous din_valid falling and cfg_req in RUN (SAFE_SWITCH=1): apply immediately, no PEND.
- Reset (any time, including mid-switch):
  - flt_mode=RESET_MODE, cnt=0, vpipe=0, cfg_ack=0, state FILL.
  - Outputs: dout_valid=0, dout=0, busy=1.
  - A request pending at reset is discarded; the requester must re-assert.

Test Plan:
- Reset (rst high) then release, cfg_req=0, continuous din_valid from cycle 1, mode 0 -> dout_valid first high in cycle 2, busy falls in cycle 3.
- In FILL, cfg_req with mode 2 in cycle 0 -> cfg_ack in cycle 1, flt_mode=2; stream from cycle 1 -> dout_valid first in cycle 8, none before.
- Mode 3, continuous stream from cycle 1 -> first dout_valid in cycle 10; din_valid low in cycle 20 only -> results for samples through cycle 19 stay valid through cycle 22. cnt restarts, so the next valid is in cycle 30, with dout=0 in invalid cycles.
- SAFE_SWITCH=1, RUN in mode 1, cfg_req mode 3 held with a continuous stream -> state PEND, no ack; din_valid drops in cycle k -> cfg_ack in k+1, flt_mode=3, vpipe cleared.
- SAFE_SWITCH=0, RUN in mode 2, cfg_req mode 1 -> ack next cycle, dout_valid low, busy high; the new first valid follows after W-1+L=5 cycles of stream.
- Assert rst in PEND with cfg_req high -> immediate flt_mode=RESET_MODE, cfg_ack never pulses, dout_valid=0, busy=1.

Source files
------------

// File: rtl/smooth_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : smooth_filter_ctrl
// Brief  : Mode sequencer and output-valid tracker for the smoothing filter.
// Rev    : 1.0
// ============================================================================
module smooth_filter_ctrl #(
    parameter bit         SAFE_SWITCH = 1'b1,
    parameter logic [1:0] RESET_MODE  = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic       cfg_req,
    input  logic [1:0] cfg_mode,
    output logic       cfg_ack,
    output logic [1:0] flt_mode,
    input  logic [7:0] flt_dout,
    output logic       dout_valid,
    output logic [7:0] dout,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [2:0] C_CNT_MAX = 3'd7;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_flt_mode;
    logic [2:0] r_cnt;
    logic [2:0] r_vpipe;
    logic       r_cfg_ack;
    logic [2:0] w_win;
    logic       w_win_ok;
    logic       w_dout_valid;
    logic       w_req;
    logic       w_new_mode;
    logic       w_apply;
    logic       w_ack_nxt;

    always_comb begin
        case (r_flt_mode)
            2'd0:    w_win = 3'd1;
            2'd1:    w_win = 3'd3;
            2'd2:    w_win = 3'd5;
            default: w_win = 3'd7;
        endcase
    end

    assign w_win_ok     = din_valid && (({1'b0, r_cnt} + 4'd1) >= {1'b0, w_win});
    assign w_dout_valid = (r_flt_mode == 2'd0) ? r_vpipe[0] : r_vpipe[2];
    // A request is ignored in the cycle its previous ack is visible
    assign w_req        = cfg_req && !r_cfg_ack;
    assign w_new_mode   = (cfg_mode != r_flt_mode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        // Same-mode requests are acknowledged without disturbing the stream
        w_ack_nxt   = w_req && !w_new_mode;
        case (r_state)
            S_FILL: begin
                if (w_req && w_new_mode) begin
                    w_apply = 1'b1;
                end else if (w_dout_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_req && w_new_mode) begin
                    if (SAFE_SWITCH && din_valid) begin
                        w_state_nxt = S_PEND;
                    end else begin
                        w_apply = 1'b1;
                    end
                end else if (!din_valid) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_PEND: begin
                if (!cfg_req) begin
                    w_state_nxt = din_valid ? S_RUN : S_FILL;
                end else if (!din_valid) begin
                    w_apply = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
        if (w_apply) begin
            w_state_nxt = S_FILL;
            w_ack_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flt_mode <= RESET_MODE;
            r_cnt      <= 3'd0;
            r_vpipe    <= 3'd0;
            r_cfg_ack  <= 1'b0;
        end else begin
            r_cfg_ack <= w_ack_nxt;
            if (w_apply) begin
                r_flt_mode <= cfg_mode;
                r_cnt      <= 3'd0;
                r_vpipe    <= 3'd0;
            end else begin
                r_vpipe <= {r_vpipe[1:0], w_win_ok};
                if (!din_valid) begin
                    r_cnt <= 3'd0;
                end else if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    assign cfg_ack    = r_cfg_ack;
    assign flt_mode   = r_flt_mode;
    assign dout_valid = w_dout_valid;
    assign dout       = w_dout_valid ? flt_dout : 8'd0;
    assign busy       = (r_state != S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_smooth_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_smooth_filter_ctrl
// Brief  : Checks a deferring and an immediate-switch controller against a model.
// Rev    : 1.0
// ============================================================================
module tb_smooth_filter_ctrl;

    localparam int PH_FILL = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_PEND = 2;
    localparam logic [12:0] C_RST_VEC = {1'b0, 8'h00, 1'b1, 2'd0, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       cfg_req;
    logic [1:0] cfg_mode;
    logic [7:0] flt_dout;

    logic       ack_o  [2];
    logic [1:0] fm_o   [2];
    logic       dv_o   [2];
    logic [7:0] dout_o [2];
    logic       busy_o [2];

    int n_checks;
    int n_err;

    // Behavioural model: index 0 defers switches, index 1 switches at once
    int         m_phase [2];
    logic [1:0] m_mode  [2];
    int         m_fill  [2];
    bit         m_ack   [2];
    bit         m_hist  [2][3];

    always #5 clk = ~clk;

    smooth_filter_ctrl #(.SAFE_SWITCH(1'b1), .RESET_MODE(2'd0)) dut_safe (
        .clk(clk), .rst(rst), .din_valid(din_valid), .cfg_req(cfg_req),
        .cfg_mode(cfg_mode), .cfg_ack(ack_o[0]), .flt_mode(fm_o[0]),
        .flt_dout(flt_dout), .dout_valid(dv_o[0]), .dout(dout_o[0]), .busy(busy_o[0])
    );

    smooth_filter_ctrl #(.SAFE_SWITCH(1'b0), .RESET_MODE(2'd0)) dut_imm (
        .clk(clk), .rst(rst), .din_valid(din_valid), .cfg_req(cfg_req),
        .cfg_mode(cfg_mode), .cfg_ack(ack_o[1]), .flt_mode(fm_o[1]),
        .flt_dout(flt_dout), .dout_valid(dv_o[1]), .dout(dout_o[1]), .busy(busy_o[1])
    );

    function automatic logic [12:0] got_vec(input int i);
        return {dv_o[i], dout_o[i], busy_o[i], fm_o[i], ack_o[i]};
    endfunction

    function automatic logic [12:0] exp_vec(input int i);
        logic v;
        int   l;
        l = (m_mode[i] == 2'd0) ? 1 : 3;
        v = m_hist[i][l-1];
        return {v, (v ? flt_dout : 8'h00), (m_phase[i] != PH_RUN), m_mode[i], m_ack[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = PH_FILL;
            m_mode[i]  = 2'd0;
            m_fill[i]  = 0;
            m_ack[i]   = 1'b0;
            for (int k = 0; k < 3; k++) m_hist[i][k] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit safe);
        int w;
        int ph_n;
        bit win, valid, req, diff, flush, ack_n;
        w     = 2 * int'(m_mode[i]) + 1;
        win   = din_valid && (m_fill[i] + 1 >= w);
        valid = m_hist[i][(m_mode[i] == 2'd0) ? 0 : 2];
        req   = cfg_req && !m_ack[i];
        diff  = req && (cfg_mode != m_mode[i]);
        ack_n = req && !diff;
        flush = 1'b0;
        ph_n  = m_phase[i];
        case (m_phase[i])
            PH_FILL: begin
                if (diff) flush = 1'b1;
                else if (valid) ph_n = PH_RUN;
            end
            PH_RUN: begin
                if (diff) begin
                    if (safe && din_valid) ph_n = PH_PEND;
                    else flush = 1'b1;
                end else if (!din_valid) begin
                    ph_n = PH_FILL;
                end
            end
            default: begin
                if (!cfg_req) ph_n = din_valid ? PH_RUN : PH_FILL;
                else if (!din_valid) flush = 1'b1;
            end
        endcase
        if (flush) begin
            m_mode[i] = cfg_mode;
            m_fill[i] = 0;
            for (int k = 0; k < 3; k++) m_hist[i][k] = 1'b0;
            ack_n = 1'b1;
            ph_n  = PH_FILL;
        end else begin
            m_hist[i][2] = m_hist[i][1];
            m_hist[i][1] = m_hist[i][0];
            m_hist[i][0] = win;
            m_fill[i]    = din_valid ? m_fill[i] + 1 : 0;
        end
        m_ack[i]   = ack_n;
        m_phase[i] = ph_n;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        cfg_req   = 1'b0;
        cfg_mode  = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        din_valid = 1'b1;
        cfg_req   = 1'b1;
        cfg_mode  = 2'd3;
        flt_dout  = 8'hA5;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_vec(i) !== C_RST_VEC) begin
                n_err++;
                $display("FAIL reset_state dut%0d got=%h exp=%h", i, got_vec(i), C_RST_VEC);
            end
        end
        #1;
        rst = 1'b0;
        cfg_req = 1'b0;
        for (int c = 0; c < 7; c++) begin
            din_valid = (c >= 1);
            flt_dout  = 8'($urandom);
            #3;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_err++;
                    $display("FAIL mode0_model dut%0d c=%0d got=%h exp=%h", i, c, got_vec(i), exp_vec(i));
                end
                n_checks++;
                if (dv_o[i] !== (c >= 2) || busy_o[i] !== (c < 3)) begin
                    n_err++;
                    $display("FAIL mode0_first_valid dut%0d c=%0d got dv=%b busy=%b exp dv=%b busy=%b",
                             i, c, dv_o[i], busy_o[i], (c >= 2), (c < 3));
                end
            end
            tick();
        end
    endtask

    task automatic test_fill_mode2();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            cfg_req   = (c == 0);
            cfg_mode  = 2'd2;
            din_valid = (c >= 1);
            flt_dout  = 8'($urandom);
            #3;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_err++;
                    $display("FAIL fill2_model dut%0d c=%0d got=%h exp=%h", i, c, got_vec(i), exp_vec(i));
                end
                n_checks++;
                if (ack_o[i] !== (c == 1) || dv_o[i] !== (c >= 8) ||
                    (c >= 1 && fm_o[i] !== 2'd2)) begin
                    n_err++;
                    $display("FAIL fill2_timing dut%0d c=%0d got ack=%b dv=%b mode=%0d exp ack=%b dv=%b mode=2",
                             i, c, ack_o[i], dv_o[i], fm_o[i], (c == 1), (c >= 8));
                end
            end
            tick();
        end
    endtask

    task automatic test_gap_mode3();
        bit ev;
        apply_reset();
        for (int c = 0; c < 33; c++) begin
            cfg_req   = (c == 0);
            cfg_mode  = 2'd3;
            din_valid = (c >= 1) && (c != 20);
            flt_dout  = 8'($urandom);
            ev        = (c >= 10 && c <= 22) || (c >= 30);
            #3;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_err++;
                    $display("FAIL gap3_model dut%0d c=%0d got=%h exp=%h", i, c, got_vec(i), exp_vec(i));
                end
                n_checks++;
                if (dv_o[i] !== ev || dout_o[i] !== (ev ? flt_dout : 8'h00)) begin
                    n_err++;
                    $display("FAIL gap3_drain dut%0d c=%0d got dv=%b dout=%h exp dv=%b dout=%h",
                             i, c, dv_o[i], dout_o[i], ev, (ev ? flt_dout : 8'h00));
                end
            end
            tick();
        end
    endtask

    task automatic test_safe_pend();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            cfg_req   = (c == 0) || (c >= 10 && c <= 16);
            cfg_mode  = (c == 0) ? 2'd1 : 2'd3;
            din_valid = (c >= 1) && (c != 16);
            flt_dout  = 8'($urandom);
            #3;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_err++;
                    $display("FAIL pend_model dut%0d c=%0d got=%h exp=%h", i, c, got_vec(i), exp_vec(i));
                end
            end
            if (c >= 11 && c <= 16) begin
                n_checks++;
                if (busy_o[0] !== 1'b1 || ack_o[0] !== 1'b0 || fm_o[0] !== 2'd1 || dv_o[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL pend_hold c=%0d got busy=%b ack=%b mode=%0d dv=%b exp busy=1 ack=0 mode=1 dv=1",
                             c, busy_o[0], ack_o[0], fm_o[0], dv_o[0]);
                end
            end
            if (c == 17 || c == 18) begin
                n_checks++;
                if (ack_o[0] !== (c == 17) || fm_o[0] !== 2'd3 || dv_o[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL pend_apply c=%0d got ack=%b mode=%0d dv=%b exp ack=%b mode=3 dv=0",
                             c, ack_o[0], fm_o[0], dv_o[0], (c == 17));
                end
            end
            if (c == 11) begin
                n_checks++;
                if (ack_o[1] !== 1'b1 || fm_o[1] !== 2'd3 || dv_o[1] !== 1'b0 || busy_o[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL imm_apply_in_stream got ack=%b mode=%0d dv=%b busy=%b exp 1 3 0 1",
                             ack_o[1], fm_o[1], dv_o[1], busy_o[1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_imm_switch();
        apply_reset();
        for (int c = 0; c < 21; c++) begin
            cfg_req   = (c == 0) || (c == 12);
            cfg_mode  = (c == 0) ? 2'd2 : 2'd1;
            din_valid = (c >= 1);
            flt_dout  = 8'($urandom);
            #3;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_err++;
                    $display("FAIL imm_model dut%0d c=%0d got=%h exp=%h", i, c, got_vec(i), exp_vec(i));
                end
            end
            if (c == 13) begin
                n_checks++;
                if (ack_o[1] !== 1'b1 || fm_o[1] !== 2'd1 || busy_o[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL imm_ack got ack=%b mode=%0d busy=%b exp 1 1 1", ack_o[1], fm_o[1], busy_o[1]);
                end
            end
            if (c >= 13 && c <= 18) begin
                n_checks++;
                if (dv_o[1] !== (c == 18)) begin
                    n_err++;
                    $display("FAIL imm_refill c=%0d got dv=%b exp dv=%b", c, dv_o[1], (c == 18));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_in_pend();
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            cfg_req   = (c == 0) || (c >= 10);
            cfg_mode  = (c == 0) ? 2'd1 : 2'd3;
            din_valid = (c >= 1);
            flt_dout  = 8'($urandom);
            #3;
            n_checks++;
            if (got_vec(0) !== exp_vec(0)) begin
                n_err++;
                $display("FAIL rstpend_model c=%0d got=%h exp=%h", c, got_vec(0), exp_vec(0));
            end
            if (c == 13) begin
                n_checks++;
                if (busy_o[0] !== 1'b1 || ack_o[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstpend_in_pend got busy=%b ack=%b exp busy=1 ack=0", busy_o[0], ack_o[0]);
                end
                rst = 1'b1;
                model_reset();
                #1;
                for (int i = 0; i < 2; i++) begin
                    n_checks++;
                    if (got_vec(i) !== C_RST_VEC) begin
                        n_err++;
                        $display("FAIL rstpend_async dut%0d got=%h exp=%h", i, got_vec(i), C_RST_VEC);
                    end
                end
            end
            tick();
        end
        din_valid = 1'b0;
        #3;
        n_checks++;
        if (got_vec(0) !== C_RST_VEC) begin
            n_err++;
            $display("FAIL rstpend_held got=%h exp=%h", got_vec(0), C_RST_VEC);
        end
        tick();
        rst       = 1'b0;
        cfg_req   = 1'b0;
        din_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            flt_dout = 8'($urandom);
            #3;
            n_checks++;
            if (got_vec(0) !== exp_vec(0) || ack_o[0] !== 1'b0) begin
                n_err++;
                $display("FAIL rstpend_discard c=%0d got=%h exp=%h", c, got_vec(0), exp_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            din_valid = ($urandom_range(0, 9) != 0);
            flt_dout  = 8'($urandom);
            if (!cfg_req) begin
                if ($urandom_range(0, 5) == 0) begin
                    cfg_req  = 1'b1;
                    cfg_mode = 2'($urandom_range(0, 3));
                end
            end else if (m_ack[0] || $urandom_range(0, 9) == 0) begin
                cfg_req = 1'b0;
            end
            #3;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    n_err++;
                    $display("FAIL random_model dut%0d c=%0d got=%h exp=%h", i, c, got_vec(i), exp_vec(i));
                end
            end
            tick();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        din_valid = 1'b0;
        cfg_req   = 1'b0;
        cfg_mode  = 2'd0;
        flt_dout  = 8'h00;
        model_reset();
        test_reset();
        test_fill_mode2();
        test_gap_mode3();
        test_safe_pend();
        test_imm_switch();
        test_reset_in_pend();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
